uart_tx_sched: RTL

//  Round-robin scheduler sharing one UART transmitter between NUM_REQ byte producers.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_sched_rr_pick.sv | 36 +++
 rtl/uart_tx_sched.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_pkg
// Brief  : Shared state encoding and byte width for the UART TX scheduler.
// Rev    : 1.0
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_sched_rr_pick.sv
`default_nettype none
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin picker: first set request at or above ptr.
// Rev    : 1.0
// ============================================================================
module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt_oh,
    output logic             valid
);

    // First pass covers [ptr, N-1]; second pass wraps around to [0, ptr-1].
    always_comb begin
        gnt_oh = '0;
        valid  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!valid && req[i] && (i >= int'(ptr))) begin
                gnt_oh[i] = 1'b1;
                valid     = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!valid && req[i]) begin
                gnt_oh[i] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_sched
// Brief  : Round-robin scheduler sharing one UART transmitter among NUM_REQ
//          producers, with burst lock. Optional timeout: UART_TX_SCHED_TIMEOUT_EN.
// Rev    : 1.0
// ============================================================================
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = UART_DATA_W,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      tx_en,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_busy,
    output logic                      err
);

    localparam int               PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    if (NUM_REQ < 1) begin : g_chk_num_req
        $error("uart_tx_sched: NUM_REQ must be >= 1");
    end
    if (TIMEOUT_CYC < 2) begin : g_chk_timeout
        $error("uart_tx_sched: TIMEOUT_CYC must be >= 2");
    end

    sched_state_t         r_state;
    sched_state_t         w_next;
    logic [PTR_W-1:0]     r_ptr;
    logic [PTR_W-1:0]     r_owner;
    logic [PTR_W-1:0]     w_pick_idx;
    logic [PTR_W-1:0]     w_ptr_adv;
    logic [NUM_REQ-1:0]   w_pick_oh;
    logic                 w_pick_valid;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   r_ack;
    logic                 r_tx_en;
    logic [DATA_W-1:0]    r_tx_data;
    logic                 r_lock;
    logic                 r_err;
    logic                 w_waiting;
    logic                 w_wait_done;
    logic                 w_timeout;
    logic                 w_grant;
    logic                 w_issue;
    logic                 w_release;

    rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req    (req),
        .ptr    (r_ptr),
        .gnt_oh (w_pick_oh),
        .valid  (w_pick_valid)
    );

    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick_oh[i]) begin
                w_pick_idx = PTR_W'(i);
            end
        end
    end

    assign w_ptr_adv   = (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;
    assign w_waiting   = (r_state == WAIT_HI) || (r_state == WAIT_LO);
    assign w_wait_done = ((r_state == WAIT_HI) &&  tx_busy) ||
                         ((r_state == WAIT_LO) && !tx_busy);

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    logic [CNT_W-1:0] r_wait_cnt;

    // Restarts from zero on every entry into WAIT_HI / WAIT_LO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (w_waiting && !w_wait_done && !w_timeout) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end else begin
            r_wait_cnt <= '0;
        end
    end

    assign w_timeout = w_waiting && !w_wait_done &&
                       (r_wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (!tx_busy && w_pick_valid) w_next = START;
            START:   w_next = WAIT_HI;
            WAIT_HI: begin
                if (w_timeout)    w_next = IDLE;
                else if (tx_busy) w_next = WAIT_LO;
            end
            WAIT_LO: begin
                if (w_timeout)     w_next = IDLE;
                else if (!tx_busy) w_next = (r_lock && req[r_owner]) ? START : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_grant   = 1'b0;
        w_issue   = 1'b0;
        w_release = 1'b0;
        case (r_state)
            IDLE:    w_grant   = (w_next == START);
            START:   w_issue   = 1'b1;
            WAIT_HI: w_release = w_timeout;
            WAIT_LO: w_release = (w_next == IDLE);
            default: ;
        endcase
    end

    // Strobes default low so ack/tx_en/err can only ever be single-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr     <= '0;
            r_owner   <= '0;
            r_gnt     <= '0;
            r_ack     <= '0;
            r_tx_en   <= 1'b0;
            r_tx_data <= '0;
            r_lock    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_ack   <= '0;
            r_tx_en <= 1'b0;
            r_err   <= 1'b0;
            if (w_grant) begin
                r_gnt   <= w_pick_oh;
                r_owner <= w_pick_idx;
            end
            if (w_issue) begin
                r_tx_en   <= 1'b1;
                r_tx_data <= req_data[int'(r_owner) * DATA_W +: DATA_W];
                r_ack     <= r_gnt;
                r_lock    <= ~req_last[r_owner];
            end
            if (w_release) begin
                r_gnt  <= '0;
                r_ptr  <= w_ptr_adv;
                r_lock <= 1'b0;
                r_err  <= w_timeout;
            end
        end
    end

    assign ack     = r_ack;
    assign gnt     = r_gnt;
    assign tx_en   = r_tx_en;
    assign tx_data = r_tx_data;
    assign err     = r_err;

endmodule
`default_nettype wire
